simd_mem_client: RTL and testbench

- Core-side requester for the shared 8-bit scratch RAM arbiter: one lane per core.
- Converts per-core load/store requests into the arbiter's packed rden/wren/Address/Din interface.
- Waits for the per-lane acq grant, holds through the RAM read latency, and captures the lane's byte from Dq.
- Returns a one-cycle response per request; sits between the core datapaths and the arbiter.

---
 rtl/simd_mem_pkg.sv | 18 +
 rtl/simd_lane_ctrl.sv | 120 ++++++++++++
 rtl/simd_mem_client.sv | 54 +++++
 tb/tb_simd_mem_client.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_mem_pkg.sv
// Shared types and lane geometry for the SIMD scratch-RAM client.
package simd_mem_pkg;

   localparam int LANE_W = 8;
   localparam int WAIT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_RESP = 2'd3
   } lane_state_t;

   function automatic int lane_lo(input int lane);
      return lane * LANE_W;
   endfunction

endpackage

// File: rtl/simd_lane_ctrl.sv
// One core lane: latches a load/store, waits for its grant, rides out the RAM
// read latency and returns a single-cycle response.
module simd_lane_ctrl
   import simd_mem_pkg::*;
#(
   parameter int RD_LAT = 2,
   parameter int TMO    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [LANE_W-1:0] req_addr,
   input  logic [LANE_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [LANE_W-1:0] rsp_rdata,
   output logic              rden,
   output logic              wren,
   output logic [LANE_W-1:0] addr,
   output logic [LANE_W-1:0] din,
   input  logic              acq,
   input  logic [LANE_W-1:0] dq
);

   localparam int                LAT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
   localparam logic [LAT_W-1:0]  LAT_END  = LAT_W'(RD_LAT);
   localparam logic [WAIT_W-1:0] TMO_END  = WAIT_W'(TMO);
   localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

   lane_state_t       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              we_q, we_n;
   logic              accept, capture, timeout, busy_d;

   assign req_ready = (state_q == ST_IDLE);

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      lat_d    = lat_q;
      capture  = 1'b0;
      timeout  = 1'b0;
      accept   = (state_q == ST_IDLE) && req_valid;
      wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_REQ;
               wait_d  = '0;
               lat_d   = '0;
            end
         end
         ST_REQ: begin
            if (acq) begin
               state_d = ST_HOLD;
               lat_d   = '0;
            end else begin
               wait_d = wait_inc;
               if ((TMO > 0) && (wait_inc == TMO_END)) begin
                  state_d = ST_RESP;
                  timeout = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            // Losing the grant mid-latency restarts the read, but the
            // overall wait budget keeps running.
            if (!acq) begin
               state_d = ST_REQ;
               lat_d   = '0;
            end else if (lat_q == LAT_END) begin
               state_d = ST_RESP;
               capture = 1'b1;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      we_n   = accept ? req_we : we_q;
      busy_d = (state_d == ST_REQ) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         lat_q     <= '0;
         rden      <= 1'b0;
         wren      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         addr      <= '0;
         din       <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         lat_q     <= lat_d;
         rden      <= busy_d && !we_n;
         wren      <= busy_d && we_n;
         rsp_valid <= (state_d == ST_RESP);
         rsp_err   <= timeout;
         rsp_rdata <= (capture && !we_q) ? dq : '0;
         if (accept) begin
            addr <= req_addr;
            din  <= req_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) we_q <= req_we;
   end

endmodule

// File: rtl/simd_mem_client.sv
// Per-core requester front end for the shared scratch-RAM arbiter; only packs
// and unpacks the lane buses around NCORES lane controllers.
module simd_mem_client
   import simd_mem_pkg::*;
#(
   parameter int NCORES = 4,
   parameter int RD_LAT = 2,
   parameter int TMO    = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCORES-1:0]        req_valid,
   input  logic [NCORES-1:0]        req_we,
   input  logic [NCORES*LANE_W-1:0] req_addr,
   input  logic [NCORES*LANE_W-1:0] req_wdata,
   output logic [NCORES-1:0]        req_ready,
   output logic [NCORES-1:0]        rsp_valid,
   output logic [NCORES-1:0]        rsp_err,
   output logic [NCORES*LANE_W-1:0] rsp_rdata,
   output logic [NCORES-1:0]        rden,
   output logic [NCORES-1:0]        wren,
   output logic [NCORES*LANE_W-1:0] Address,
   output logic [NCORES*LANE_W-1:0] Din,
   input  logic [NCORES-1:0]        acq,
   input  logic [NCORES*LANE_W-1:0] Dq
);

   for (genvar g = 0; g < NCORES; g++) begin : g_lane
      localparam int LO = lane_lo(g);

      simd_lane_ctrl #(
         .RD_LAT (RD_LAT),
         .TMO    (TMO)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[LO +: LANE_W]),
         .req_wdata (req_wdata[LO +: LANE_W]),
         .req_ready (req_ready[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_err   (rsp_err[g]),
         .rsp_rdata (rsp_rdata[LO +: LANE_W]),
         .rden      (rden[g]),
         .wren      (wren[g]),
         .addr      (Address[LO +: LANE_W]),
         .din       (Din[LO +: LANE_W]),
         .acq       (acq[g]),
         .dq        (Dq[LO +: LANE_W])
      );
   end

endmodule

// File: tb/tb_simd_mem_client.sv
// Scoreboard bench for simd_mem_client: directed scenarios plus random traffic
// against a cycle-level behavioural model of each lane.
module tb_simd_mem_client;

   localparam int NC     = 4;
   localparam int RD_LAT = 2;
   localparam int TMO    = 8;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_HOLD = 2;
   localparam int M_RESP = 3;

   logic            clk;
   logic            rst;
   logic [NC-1:0]   req_valid, req_we, req_ready;
   logic [NC*8-1:0] req_addr, req_wdata;
   logic [NC-1:0]   rsp_valid, rsp_err, rden, wren, acq;
   logic [NC*8-1:0] rsp_rdata, Address, Din, Dq;

   simd_mem_client #(
      .NCORES (NC),
      .RD_LAT (RD_LAT),
      .TMO    (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .rden      (rden),
      .wren      (wren),
      .Address   (Address),
      .Din       (Din),
      .acq       (acq),
      .Dq        (Dq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference model: one entry per lane, advanced once per rising edge.
   typedef struct {
      int         cyc;
      logic       err;
      logic [7:0] rdata;
   } exp_t;

   exp_t       exp_q[NC][$];
   exp_t       mon_e;
   int         ph[NC];
   int         waited[NC];
   int         held[NC];
   logic       m_we[NC];
   logic [7:0] m_addr[NC];
   logic [7:0] m_din[NC];

   initial begin
      for (int i = 0; i < NC; i++) begin
         ph[i] = M_IDLE; waited[i] = 0; held[i] = 0;
         m_we[i] = 1'b0; m_addr[i] = 8'h00; m_din[i] = 8'h00;
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < NC; i++) begin
            if (rst) begin
               ph[i] = M_IDLE;
               m_addr[i] = 8'h00;
               m_din[i] = 8'h00;
               exp_q[i].delete();
            end else begin
               case (ph[i])
                  M_IDLE: if (req_valid[i]) begin
                     ph[i] = M_WAIT;
                     waited[i] = 0;
                     m_we[i] = req_we[i];
                     m_addr[i] = req_addr[8*i +: 8];
                     m_din[i] = req_wdata[8*i +: 8];
                  end
                  M_WAIT: if (acq[i]) begin
                     ph[i] = M_HOLD;
                     held[i] = 0;
                  end else begin
                     waited[i] = (waited[i] < 255) ? waited[i] + 1 : 255;
                     if (TMO > 0 && waited[i] >= TMO) begin
                        ph[i] = M_RESP;
                        exp_q[i].push_back('{cyc, 1'b1, 8'h00});
                     end
                  end
                  M_HOLD: if (!acq[i]) begin
                     ph[i] = M_WAIT;
                  end else if (held[i] >= RD_LAT) begin
                     ph[i] = M_RESP;
                     exp_q[i].push_back('{cyc, 1'b0, m_we[i] ? 8'h00 : Dq[8*i +: 8]});
                  end else begin
                     held[i]++;
                  end
                  default: ph[i] = M_IDLE;
               endcase
            end
         end
      end
   end

   // Monitor: compares every lane on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NC; i++) begin
            if (rsp_valid[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk($sformatf("rsp_valid_unexpected[%0d]", i), 1, 0);
               end else begin
                  mon_e = exp_q[i].pop_front();
                  chk($sformatf("rsp_cycle[%0d]", i), cyc, mon_e.cyc);
                  chk($sformatf("rsp_err[%0d]", i), rsp_err[i], mon_e.err);
                  chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[8*i +: 8], mon_e.rdata);
               end
            end else begin
               if (exp_q[i].size() > 0 && exp_q[i][0].cyc <= cyc) begin
                  chk($sformatf("rsp_valid_missing[%0d]", i), 0, 1);
                  void'(exp_q[i].pop_front());
               end
               chk($sformatf("rsp_err_idle[%0d]", i), rsp_err[i], 0);
               chk($sformatf("rsp_rdata_idle[%0d]", i), rsp_rdata[8*i +: 8], 0);
            end
            chk($sformatf("req_ready[%0d]", i), req_ready[i], ph[i] == M_IDLE);
            chk($sformatf("rden[%0d]", i), rden[i],
                (ph[i] == M_WAIT || ph[i] == M_HOLD) && !m_we[i]);
            chk($sformatf("wren[%0d]", i), wren[i],
                (ph[i] == M_WAIT || ph[i] == M_HOLD) && m_we[i]);
            chk($sformatf("Address[%0d]", i), Address[8*i +: 8], m_addr[i]);
            chk($sformatf("Din[%0d]", i), Din[8*i +: 8], m_din[i]);
         end
      end
   end

   task automatic send(input int lane, input logic we, input logic [7:0] a,
                       input logic [7:0] d, output int t_acc);
      int n = 0;
      while (!req_ready[lane] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[lane]) chk("send_ready_timeout", 0, 1);
      req_valid[lane]        = 1'b1;
      req_we[lane]           = we;
      req_addr[8*lane +: 8]  = a;
      req_wdata[8*lane +: 8] = d;
      @(negedge clk);
      req_valid[lane] = 1'b0;
      t_acc = cyc - 1;
   endtask

   task automatic wait_rsp(input int lane, output int t_rsp);
      int n = 0;
      while (!rsp_valid[lane] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid[lane]) chk("rsp_wait_timeout", 0, 1);
      t_rsp = cyc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, n;
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      acq = '0; Dq = '0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", req_ready, 4'hF);
      chk("reset_rsp_valid", rsp_valid, 4'h0);
      chk("reset_rden_wren", {rden, wren}, 8'h00);
      chk("reset_Address", Address, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single load, lane 1, immediate grant.
      Dq = 32'h5A5A5A5A;
      send(1, 1'b0, 8'h3C, 8'h00, t0);
      chk("t1_rden_after_accept", rden[1], 1);
      chk("t1_Address", Address[15:8], 8'h3C);
      acq[1] = 1'b1;
      wait_rsp(1, t1);
      chk("t1_latency", t1 - t0, 5);
      chk("t1_rdata", rsp_rdata[15:8], 8'h5A);
      chk("t1_err", rsp_err[1], 0);
      chk("t1_ready_during_rsp", req_ready[1], 0);
      @(negedge clk);
      acq[1] = 1'b0;
      chk("t1_ready_after_rsp", req_ready[1], 1);
      chk("t1_single_pulse", rsp_valid[1], 0);

      // Store, lane 0.
      send(0, 1'b1, 8'h10, 8'hA7, t0);
      chk("t2_wren", wren[0], 1);
      chk("t2_rden", rden[0], 0);
      chk("t2_Address", Address[7:0], 8'h10);
      chk("t2_Din", Din[7:0], 8'hA7);
      acq[0] = 1'b1;
      wait_rsp(0, t1);
      chk("t2_latency", t1 - t0, 5);
      chk("t2_rdata", rsp_rdata[7:0], 8'h00);
      @(negedge clk);
      acq[0] = 1'b0;

      // Grant preemption on lane 2: 1 high, 3 low, then high.
      Dq = $urandom;
      send(2, 1'b0, 8'h44, 8'h00, t0);
      acq[2] = 1'b1;
      @(negedge clk); acq[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); acq[2] = 1'b1;
      wait_rsp(2, t1);
      chk("t3_latency", t1 - t0, 9);
      chk("t3_rdata", rsp_rdata[23:16], Dq[23:16]);
      @(negedge clk);
      acq[2] = 1'b0;

      // Broadcast grant, all lanes load the same address.
      Dq = 32'hC3C3C3C3;
      chk("t4_all_ready", req_ready, 4'hF);
      req_valid = 4'hF; req_we = 4'h0; req_addr = {4{8'h22}};
      @(negedge clk);
      req_valid = 4'h0;
      acq = 4'hF;
      n = 0;
      while (rsp_valid == 4'h0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_rsp_valid_all", rsp_valid, 4'hF);
      chk("t4_rdata_all", rsp_rdata, 32'hC3C3C3C3);
      @(negedge clk);
      acq = 4'h0;

      // Grant timeout on lane 3.
      send(3, 1'b0, 8'h77, 8'h00, t0);
      wait_rsp(3, t1);
      chk("t5_err", rsp_err[3], 1);
      chk("t5_within_tmo", (t1 - t0) <= TMO + 1, 1);
      chk("t5_rden_dropped", rden[3], 0);
      chk("t5_rdata_zero", rsp_rdata[31:24], 8'h00);
      @(negedge clk);

      // Reset while lane 0 is holding a grant.
      send(0, 1'b0, 8'h55, 8'h00, t0);
      acq[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      acq = 4'h0;
      chk("t6_rsp_valid", rsp_valid, 4'h0);
      chk("t6_rden_wren", {rden, wren}, 8'h00);
      chk("t6_Address", Address, 32'h0);
      chk("t6_Din", Din, 32'h0);
      chk("t6_rdata", rsp_rdata, 32'h0);
      chk("t6_req_ready", req_ready, 4'hF);
      repeat (8) @(negedge clk);

      // Random traffic.
      repeat (400) begin
         for (int i = 0; i < NC; i++) begin
            req_valid[i] = req_ready[i] && ($urandom_range(2) == 0);
            req_we[i]    = $urandom_range(1);
         end
         req_addr  = $urandom;
         req_wdata = $urandom;
         if ($urandom_range(9) == 0) begin
            acq = 4'hF;
         end else begin
            for (int i = 0; i < NC; i++) acq[i] = ($urandom_range(3) != 0);
         end
         Dq = $urandom;
         @(negedge clk);
      end
      req_valid = 4'h0;
      acq = 4'hF;
      repeat (20) @(negedge clk);
      acq = 4'h0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < NC; i++) chk($sformatf("drained[%0d]", i), exp_q[i].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
